// File: rtl/clk_div_monitor.sv
// Divided-strobe health monitor: measures edge-to-edge intervals, tracks lock, counts errors.
// Optional build macro CLK_MON_TOLERANCE_EN widens the good-period window to EXP_PERIOD +/- 1.
module clk_div_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 strobe_in,
  output logic [CNT_W-1:0]     period_out,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * EXP_PERIOD - 1);

  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_strobe_q;
  logic [CNT_W-1:0] r_cyc_cnt, w_cyc_nxt;
  logic [GW-1:0]    r_good_run, w_good_nxt;
  logic [LW-1:0]    r_bad_run, w_bad_nxt;
  logic [CNT_W-1:0] w_period;
  logic             w_edge, w_timeout, w_good, w_pv, w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_run;
    w_bad_nxt   = r_bad_run;
    w_pv        = 1'b0;
    w_err       = 1'b0;
    w_edge      = strobe_in & ~r_strobe_q;
    w_period    = r_cyc_cnt + CNT_W'(1);
    // An edge always beats a coincident timeout; that period is then simply bad.
    w_timeout   = ~w_edge && (r_cyc_cnt == TIMEOUT_CNT);
    w_cyc_nxt   = (w_edge || w_timeout) ? '0 : r_cyc_cnt + CNT_W'(1);
`ifdef CLK_MON_TOLERANCE_EN
    w_good      = (w_period >= CNT_W'(EXP_PERIOD - 1)) && (w_period <= CNT_W'(EXP_PERIOD + 1));
`else
    w_good      = (w_period == CNT_W'(EXP_PERIOD));
`endif

    case (r_state)
      ACQUIRE: begin
        if (w_edge) begin
          w_state_nxt = TRACK;
          w_good_nxt  = '0;
        end
      end
      TRACK: begin
        if (w_edge) begin
          w_pv = 1'b1;
          if (w_good) begin
            if (r_good_run == GW'(LOCK_COUNT - 1)) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
              w_good_nxt  = '0;
            end else begin
              w_good_nxt = r_good_run + GW'(1);
            end
          end else begin
            w_err      = 1'b1;
            w_good_nxt = '0;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = ACQUIRE;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          w_pv = 1'b1;
          if (w_good) begin
            w_bad_nxt = '0;
          end else begin
            w_err = 1'b1;
            if (r_bad_run == LW'(LOSS_COUNT - 1)) begin
              w_state_nxt = TRACK;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_bad_nxt = r_bad_run + LW'(1);
            end
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = ACQUIRE;
        end
      end
      default: w_state_nxt = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= ACQUIRE;
      r_strobe_q   <= 1'b0;
      r_cyc_cnt    <= '0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_strobe_q   <= strobe_in;
      r_cyc_cnt    <= w_cyc_nxt;
      r_good_run   <= w_good_nxt;
      r_bad_run    <= w_bad_nxt;
      if (w_pv) period_out <= w_period;
      period_valid <= w_pv;
      locked       <= (w_state_nxt == LOCKED);
      err_pulse    <= w_err;
      // Error count saturates at all-ones rather than wrapping.
      if (w_err && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor; a second instance with a 2-bit error
// counter shares the stimulus to exercise saturation.
module tb_clk_div_monitor;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        strobe_in;
  logic [7:0]  period_out;
  logic        period_valid, locked, err_pulse;
  logic [15:0] err_count;
  logic [7:0]  satPeriod;
  logic        satValid, satLocked, satErr;
  logic [1:0]  satCount;

  int compareCount = 0;
  int mismatchCount = 0;
  int expErr = 0;
  logic       capPv, capErr, capLocked;
  logic [7:0] capPeriod;

  always #5 clk_in = ~clk_in;

  clk_div_monitor dut (
    .clk_in(clk_in), .reset(reset), .strobe_in(strobe_in),
    .period_out(period_out), .period_valid(period_valid), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  clk_div_monitor #(.ERR_CNT_W(2)) dutSat (
    .clk_in(clk_in), .reset(reset), .strobe_in(strobe_in),
    .period_out(satPeriod), .period_valid(satValid), .locked(satLocked),
    .err_pulse(satErr), .err_count(satCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: drive at negedge, let the posedge sample, return at the next negedge.
  task automatic applyStimulus(input logic s);
    strobe_in = s;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Strobe high for one cycle, capture the outputs it produced, then stay low so the next edge is gap cycles later.
  task automatic edgeThen(input int gap);
    applyStimulus(1'b1);
    capPv     = period_valid;
    capPeriod = period_out;
    capErr    = err_pulse;
    capLocked = locked;
    for (int i = 1; i < gap; i++) applyStimulus(1'b0);
  endtask

  task automatic checkEdge(input string tag, input logic expPv, input int expPer,
                           input logic expErrPulse, input logic expLocked);
    checkOutput({tag, "/period_valid"}, 32'(capPv), 32'(expPv));
    if (expPv) checkOutput({tag, "/period_out"}, 32'(capPeriod), expPer);
    checkOutput({tag, "/err_pulse"}, 32'(capErr), 32'(expErrPulse));
    checkOutput({tag, "/locked"}, 32'(capLocked), 32'(expLocked));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/period_out"}, 32'(period_out), 0);
    checkOutput({tag, "/period_valid"}, 32'(period_valid), 0);
    checkOutput({tag, "/locked"}, 32'(locked), 0);
    checkOutput({tag, "/err_pulse"}, 32'(err_pulse), 0);
    checkOutput({tag, "/err_count"}, 32'(err_count), 0);
    checkOutput({tag, "/sat_count"}, 32'(satCount), 0);
  endtask

  initial begin
    reset = 1'b1;
    strobe_in = 1'b0;
    @(negedge clk_in);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkAllZero("reset");
    reset = 1'b0;

    // Steady 1-in-4 strobe from reset release.
    edgeThen(4);
    checkEdge("t1e1", 1'b0, 0, 1'b0, 1'b0);
    for (int e = 2; e <= 5; e++) begin
      edgeThen(4);
      checkEdge($sformatf("t1e%0d", e), 1'b1, 4, 1'b0, e == 5);
    end
    checkOutput("t1/err_count", 32'(err_count), 0);

    // One long interval while locked.
    edgeThen(6);
    checkEdge("t2pre", 1'b1, 4, 1'b0, 1'b1);
    edgeThen(4);
    expErr++;
    checkEdge("t2bad", 1'b1, 6, 1'b1, 1'b1);
    edgeThen(4);
    checkEdge("t2post", 1'b1, 4, 1'b0, 1'b1);
    checkOutput("t2/err_count", 32'(err_count), 1);

    // Two long intervals drop lock; four good ones restore it.
    edgeThen(6);
    checkEdge("t3pre", 1'b1, 4, 1'b0, 1'b1);
    edgeThen(6);
    expErr++;
    checkEdge("t3bad1", 1'b1, 6, 1'b1, 1'b1);
    edgeThen(4);
    expErr++;
    checkEdge("t3bad2", 1'b1, 6, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      edgeThen(4);
      checkEdge($sformatf("t3good%0d", k), 1'b1, 4, 1'b0, k == 4);
    end

    // Strobe stuck high: timeout 8 cycles after the last edge.
    applyStimulus(1'b1);
    checkOutput("t4edge/period_valid", 32'(period_valid), 1);
    checkOutput("t4edge/locked", 32'(locked), 1);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1);
      if (i == 7) begin
        checkOutput("t4hold7/err_pulse", 32'(err_pulse), 0);
        checkOutput("t4hold7/locked", 32'(locked), 1);
      end
    end
    applyStimulus(1'b1);
    expErr++;
    checkOutput("t4timeout/err_pulse", 32'(err_pulse), 1);
    checkOutput("t4timeout/locked", 32'(locked), 0);
    checkOutput("t4timeout/period_valid", 32'(period_valid), 0);
    applyStimulus(1'b0);
    edgeThen(4);
    checkEdge("t4ref", 1'b0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      edgeThen(4);
      checkEdge($sformatf("t4relock%0d", k), 1'b1, 4, 1'b0, k == 4);
    end
    checkOutput("t4/err_count", 32'(err_count), expErr);
    checkOutput("t4/sat_count", 32'(satCount), 3);

    // Reset glitch between clock edges is ignored.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    edgeThen(4);
    checkEdge("t5glitch", 1'b1, 4, 1'b0, 1'b1);
    checkOutput("t5glitch/err_count", 32'(err_count), expErr);

    // Reset sampled together with a strobe edge wins.
    reset = 1'b1;
    applyStimulus(1'b1);
    reset = 1'b0;
    checkAllZero("t5reset");
    expErr = 0;

    // Repeated interval of 5.
    edgeThen(5);
    checkEdge("t6ref", 1'b0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      edgeThen(5);
`ifdef CLK_MON_TOLERANCE_EN
      checkEdge($sformatf("t6int%0d", k), 1'b1, 5, 1'b0, k >= 4);
`else
      expErr++;
      checkEdge($sformatf("t6int%0d", k), 1'b1, 5, 1'b1, 1'b0);
`endif
    end
    checkOutput("t6/err_count", 32'(err_count), expErr);
    checkOutput("t6/sat_count", 32'(satCount), (expErr > 3) ? 3 : expErr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checks the divided strobe generated in the miner's clock tree and reports its health. Detects rising edges on a one-cycle-in-N strobe sampled in the source clock domain and measures the interval between edges. Compares each interval against the expected divide ratio and tracks lock with a small state machine. Counts errors for the status/debug registers. Sits beside each clock divider instance; its `locked` output gates hashing-core start.

## Interface
- `EXP_PERIOD`, 4, expected edge-to-edge interval in `clk_in` cycles; must be ≥ 2.
- `CNT_W`, 8, width of the period counter and `period_out`; 2·EXP_PERIOD must be < 2^CNT_W.
- `LOCK_COUNT`, 4, consecutive good periods needed to enter LOCKED; must be ≥ 1.
- `LOSS_COUNT`, 2, consecutive bad periods that drop LOCKED; must be ≥ 1.
- `ERR_CNT_W`, 16, width of the saturating error counter.
- `clk_in` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `strobe_in` input 1: divided strobe, already synchronous to `clk_in`; no synchronizer inside.
- `period_out` output CNT_W: last measured interval.
- `period_valid` output 1: one-cycle pulse when `period_out` is updated.
- `locked` output 1: high while in LOCKED.
- `err_pulse` output 1: one-cycle pulse per bad period or timeout.
- `err_count` output ERR_CNT_W: saturating count of `err_pulse` events.

## Operation
- Edge detect: `strobe_q` holds the previous `strobe_in`. An edge is `strobe_in & ~strobe_q`. `strobe_q` resets to 0, so a strobe that is high at reset release counts as an edge.
- Period counter `cyc_cnt` resets to 0:
  - On an edge: measured period = `cyc_cnt` + 1, then `cyc_cnt` ← 0.
  - Otherwise: `cyc_cnt` increments.
- Timeout: no edge while `cyc_cnt` == 2·EXP_PERIOD−1. This raises a timeout event and sets `cyc_cnt` ← 0.
- Good period: measured period == EXP_PERIOD (tolerance option below). Any other value is bad.
- FSM states are ACQUIRE (reset state), TRACK and LOCKED. `good_run` and `bad_run` reset to 0.
  - ACQUIRE:
    - An edge is a reference only: no `period_valid`, no compare. Go to TRACK with `good_run` = 0.
    - Timeout in ACQUIRE: no error is raised.
  - TRACK:
    - Each edge pulses `period_valid`.
    - Good period: `good_run`+1. When it reaches LOCK_COUNT, go to LOCKED with `bad_run` = 0.
    - Bad period: `err_pulse`, `good_run` ← 0.
    - Timeout: `err_pulse`, go to ACQUIRE.
  - LOCKED:
    - Good period: `bad_run` ← 0.
    - Bad period: `err_pulse`, `bad_run`+1. When it reaches LOSS_COUNT, go to TRACK with `good_run` = 0.
    - Timeout: `err_pulse`, go to ACQUIRE.
- `err_count` increments on each `err_pulse` and holds at all-ones.
- Reset values: `period_out` = 0, `period_valid` = 0, `locked` = 0, `err_pulse` = 0, `err_count` = 0. All internal state returns to ACQUIRE.

## Timing
- All outputs are registered. An edge sampled at clock edge k updates `period_out`, `period_valid`, `err_pulse` and state, visible after edge k: one cycle of latency from the strobe rising.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_COUNT-th good period. It falls in the same cycle as the `err_pulse` that exhausts LOSS_COUNT, or on a timeout.
- An edge and a timeout never coincide: the edge wins and the period is 2·EXP_PERIOD, which is bad.
- `reset` asserted at clock edge k clears everything after edge k and overrides any edge sampled at k. A `reset` pulse that is low at every rising edge has no effect.
- Steady 1-in-EXP_PERIOD strobe: `period_valid` every EXP_PERIOD cycles.

## Configuration
- `CLK_MON_TOLERANCE_EN` defined: a period is good when it is within EXP_PERIOD−1 to EXP_PERIOD+1 inclusive.
- Not defined: only an exact EXP_PERIOD is good.
- The timeout threshold is the same in both builds.

## Test plan
- Defaults, strobe high 1 cycle in 4 from reset release:
  - The first edge gives no `period_valid`.
  - Edges 2–5 give `period_out` = 4.
  - `locked` = 1 with the 5th edge's `period_valid`.
  - `err_count` = 0.
- Locked, then one interval of 6, then intervals of 4:
  - One `err_pulse`, `err_count` = 1, `locked` stays 1.
- Locked, then two intervals of 6 back to back:
  - `locked` falls with the second `err_pulse`, state is TRACK.
  - After 4 good periods `locked` returns to 1.
- Locked, then `strobe_in` held high:
  - 8 cycles after the last edge: `err_pulse`, `locked` = 0, state ACQUIRE.
  - The next edge gives no `period_valid`.
- Locked, `reset` high for one rising edge:
  - The next cycle shows all outputs 0.
  - A `reset` glitch between clock edges changes nothing.
- Interval of 5 repeated:
  - With `CLK_MON_TOLERANCE_EN`: reaches locked, no errors.
  - Without it: `err_pulse` every interval. With ERR_CNT_W = 2, `err_count` saturates at 3.
